// File: rtl/filter_scheduler.sv
// filter_scheduler: shares one 3-tap smoothing filter y = (x[n] + 2*x[n-1] + x[n-2]) >> 2
// across NCH sample channels. Each channel keeps its own two-sample history, and the
// channels are served round-robin, one sample per cycle.
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   in_valid/ready  per-channel sample handshake (in_ready is combinational and one-hot or zero)
//   in_data         packed per-channel samples, channel c at [c*W +: W]
//   clr             per-channel synchronous history clear
//   out_valid/ready registered result handshake
//   out_data        filtered result
//   out_ch          channel that produced out_data
//   out_warm        result computed from a full two-sample history
module filter_scheduler #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned CW  = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic [NCH-1:0]   clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  output logic             out_warm
);

  localparam int unsigned SW = W + 2;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);
  localparam logic [1:0] WARM_FULL = 2'd2;

  logic [W-1:0]  d1_q   [NCH];
  logic [W-1:0]  d1_d   [NCH];
  logic [W-1:0]  d2_q   [NCH];
  logic [W-1:0]  d2_d   [NCH];
  logic [1:0]    warm_q [NCH];
  logic [1:0]    warm_d [NCH];
  logic [CW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic          out_warm_q, out_warm_d;

  logic          found_hi, found_lo;
  logic [CW-1:0] win_hi, win_lo, win_c;
  logic          accept;
  logic [W-1:0]  x_sel, d1_sel, d2_sel, d1_eff, d2_eff;
  logic [1:0]    warm_sel;
  logic          clr_sel;
  logic [SW-1:0] sum_c;

  // Round-robin winner: first requester at or above the pointer, else the lowest requester.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (in_valid[c] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = CW'(c);
      end
      if (in_valid[c] && !found_hi && (CW'(c) >= ptr_q)) begin
        found_hi = 1'b1;
        win_hi   = CW'(c);
      end
    end
    win_c = found_hi ? win_hi : win_lo;
  end

  // A sample is taken only when the output register is empty or draining this cycle.
  assign accept = found_lo && (!out_valid_q || out_ready);

  always_comb begin
    in_ready = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      in_ready[c] = accept && (win_c == CW'(c));
    end
  end

  // Mux the winning channel's sample and history into the shared datapath.
  always_comb begin
    x_sel    = '0;
    d1_sel   = '0;
    d2_sel   = '0;
    warm_sel = '0;
    clr_sel  = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (win_c == CW'(c)) begin
        x_sel    = in_data[c*W +: W];
        d1_sel   = d1_q[c];
        d2_sel   = d2_q[c];
        warm_sel = warm_q[c];
        clr_sel  = clr[c];
      end
    end
  end

  // A coincident clear makes the computation see an empty history.
  assign d1_eff = clr_sel ? '0 : d1_sel;
  assign d2_eff = clr_sel ? '0 : d2_sel;
  assign sum_c  = SW'(x_sel) + (SW'(d1_eff) << 1) + SW'(d2_eff);

  // Next-state for histories, pointer and output register.
  always_comb begin
    d1_d        = d1_q;
    d2_d        = d2_q;
    warm_d      = warm_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_warm_d  = out_warm_q;

    for (int unsigned c = 0; c < NCH; c++) begin
      if (accept && (win_c == CW'(c))) begin
        d1_d[c]   = in_data[c*W +: W];
        d2_d[c]   = clr[c] ? '0 : d1_q[c];
        warm_d[c] = clr[c] ? 2'd1 :
                    ((warm_q[c] == WARM_FULL) ? WARM_FULL : warm_q[c] + 2'd1);
      end else if (clr[c]) begin
        d1_d[c]   = '0;
        d2_d[c]   = '0;
        warm_d[c] = '0;
      end
    end

    if (accept) begin
      ptr_d       = (win_c == LAST_CH) ? '0 : win_c + CW'(1);
      out_valid_d = 1'b1;
      out_data_d  = W'(sum_c >> 2);
      out_ch_d    = win_c;
      out_warm_d  = !clr_sel && (warm_sel == WARM_FULL);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        d1_q[c]   <= '0;
        d2_q[c]   <= '0;
        warm_q[c] <= '0;
      end
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_warm_q  <= 1'b0;
    end else begin
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      warm_q      <= warm_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_warm_q  <= out_warm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_warm  = out_warm_q;

endmodule
